stage_sequencer: RTL and testbench

Parametrised multicycle stage sequencer for the core's ID stage, successor to the fixed five-stage control counter. It steps an N-stage instruction cycle, latches the opcode once per instruction, issues single-cycle enable strobes (PC write, memory, stack, register write-back) at configurable stages, supports pipeline stall, and provides a HALT/resume state with a retired-instruction counter. The combinational opcode-to-mux decode (ALU op, data selects, pcSrc) remains a separate block; this block owns only *when* things happen.

---
 rtl/stage_sequencer.sv | 116 +++++++++++
 tb/tb_stage_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer.sv
// Multicycle instruction-stage sequencer: steps NUM_STAGES stages per instruction,
// latches the opcode once, and issues single-cycle enable strobes at configurable stages.
module stage_sequencer #(
  parameter int NUM_STAGES  = 5,
  parameter int PC_STAGE    = 3,
  parameter int MEM_STAGE   = 2,
  parameter int STACK_STAGE = 2,
  parameter int COUNT_W     = 16,
  parameter int SW          = $clog2(NUM_STAGES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               stall,
  input  logic               resume,
  output logic [SW-1:0]      stage,
  output logic [5:0]         op_q,
  output logic               pc_write,
  output logic               mem_read_en,
  output logic               mem_write_en,
  output logic               push,
  output logic               pop,
  output logic               reg_write_en,
  output logic               instr_done,
  output logic               halted,
  output logic [COUNT_W-1:0] retired
);

  // state  | meaning
  // RUN    | stepping stages, strobes decoded from stage/op_q
  // HALTED | parked at stage 0 after a retired HALT, waits for resume

  typedef enum logic {RUN, HALTED} state_t;

  localparam logic [SW-1:0] LAST_S  = SW'(NUM_STAGES - 1);
  localparam logic [SW-1:0] PC_S    = SW'(PC_STAGE);
  localparam logic [SW-1:0] MEM_S   = SW'(MEM_STAGE);
  localparam logic [SW-1:0] STACK_S = SW'(STACK_STAGE);

  localparam logic [5:0] OP_HALT = 6'b111111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_CALL = 6'b000011;
  localparam logic [5:0] OP_RET  = 6'b000001;

  state_t        state_q, state_d;
  logic [SW-1:0] stage_q, stage_d;
  logic          active;
  logic          latch_op;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      stage_q <= '0;
      op_q    <= 6'h00;
      retired <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      if (latch_op)   op_q    <= opcode;
      if (instr_done) retired <= retired + COUNT_W'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    stage_d      = stage_q;
    active       = (state_q == RUN) && !stall;
    latch_op     = active && (stage_q == '0);
    pc_write     = 1'b0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
    reg_write_en = 1'b0;
    instr_done   = 1'b0;

    case (state_q)
      RUN: begin
        if (!stall) begin
          if (stage_q == LAST_S) begin
            stage_d = '0;
            if (op_q == OP_HALT) state_d = HALTED;
          end else begin
            stage_d = stage_q + SW'(1);
          end
        end
      end
      HALTED: begin
        stage_d = '0;
        if (resume) state_d = RUN;
      end
      default: begin
        state_d = RUN;
        stage_d = '0;
      end
    endcase

    // Strobes look only at registered state and stall; never at the live opcode.
    if (active) begin
      pc_write     = (stage_q == PC_S) && (op_q != OP_HALT);
      mem_read_en  = (stage_q == MEM_S) && (op_q == OP_LW);
      mem_write_en = (stage_q == MEM_S) && (op_q == OP_SW);
      push         = (stage_q == STACK_S) && (op_q == OP_CALL);
      pop          = (stage_q == STACK_S) && (op_q == OP_RET);
      instr_done   = (stage_q == LAST_S);
      reg_write_en = (stage_q == LAST_S) &&
                     (op_q inside {6'b000000, 6'b011100, 6'b000101, 6'b001000,
                                   6'b001001, 6'b001100, 6'b001101, 6'b100011});
    end
  end

  assign stage  = stage_q;
  assign halted = (state_q == HALTED);

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: default 5-stage instance plus an 8-stage,
// 2-bit-counter instance for the parameter variant.
module tb_stage_sequencer;

  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_CALL = 6'b000011;
  localparam logic [5:0] OP_RET  = 6'b000001;
  localparam logic [5:0] OP_HALT = 6'b111111;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode_a = OP_ADDI, opcode_b = OP_ADDI;
  logic       stall_a = 1'b0, stall_b = 1'b0;
  logic       resume_a = 1'b0, resume_b = 1'b0;

  logic [2:0]  stage_a, stage_b;
  logic [5:0]  op_q_a, op_q_b;
  logic        pcw_a, mrd_a, mwr_a, psh_a, pop_a, rwe_a, dn_a, halted_a;
  logic        pcw_b, mrd_b, mwr_b, psh_b, pop_b, rwe_b, dn_b, halted_b;
  logic [15:0] retired_a;
  logic [1:0]  retired_b;
  logic [6:0]  strb_a, strb_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  stage_sequencer dut_a (
    .clk(clk), .reset(reset), .opcode(opcode_a), .stall(stall_a), .resume(resume_a),
    .stage(stage_a), .op_q(op_q_a), .pc_write(pcw_a), .mem_read_en(mrd_a),
    .mem_write_en(mwr_a), .push(psh_a), .pop(pop_a), .reg_write_en(rwe_a),
    .instr_done(dn_a), .halted(halted_a), .retired(retired_a)
  );

  stage_sequencer #(.NUM_STAGES(8), .PC_STAGE(5), .MEM_STAGE(6), .COUNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .opcode(opcode_b), .stall(stall_b), .resume(resume_b),
    .stage(stage_b), .op_q(op_q_b), .pc_write(pcw_b), .mem_read_en(mrd_b),
    .mem_write_en(mwr_b), .push(psh_b), .pop(pop_b), .reg_write_en(rwe_b),
    .instr_done(dn_b), .halted(halted_b), .retired(retired_b)
  );

  assign strb_a = {pcw_a, mrd_a, mwr_a, psh_a, pop_a, rwe_a, dn_a};
  assign strb_b = {pcw_b, mrd_b, mwr_b, psh_b, pop_b, rwe_b, dn_b};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected strobe vector {pc,mrd,mwr,push,pop,rwe,done} for an unstalled stage.
  function automatic logic [6:0] exp_strb(input logic [5:0] op, input int s, input int n,
                                          input int pcs, input int mems, input int stks);
    logic pc, mr, mw, pu, po, rw, dn;
    pc = (s == pcs) && (op != OP_HALT);
    mr = (s == mems) && (op == OP_LW);
    mw = (s == mems) && (op == OP_SW);
    pu = (s == stks) && (op == OP_CALL);
    po = (s == stks) && (op == OP_RET);
    dn = (s == n - 1);
    rw = dn && (op inside {6'b000000, 6'b011100, 6'b000101, 6'b001000,
                           6'b001001, 6'b001100, 6'b001101, 6'b100011});
    return {pc, mr, mw, pu, po, rw, dn};
  endfunction

  task automatic run_instr(input bit sel, input logic [5:0] op, input string tag);
    int n, pcs, mems;
    n    = sel ? 8 : 5;
    pcs  = sel ? 5 : 3;
    mems = sel ? 6 : 2;
    for (int s = 0; s < n; s++) begin
      if (sel) opcode_b = op; else opcode_a = op;
      #2;
      check({tag, " stage"}, sel ? stage_b : stage_a, s);
      check({tag, " strobes"}, sel ? strb_b : strb_a, exp_strb(op, s, n, pcs, mems, 2));
      tick();
    end
  endtask

  initial begin
    #2;
    check("rst stage", stage_a, 0);
    check("rst op_q", op_q_a, 0);
    check("rst retired", retired_a, 0);
    check("rst strobes", strb_a, 0);
    check("rst halted", halted_a, 0);
    tick();
    tick();
    reset = 1'b1;

    run_instr(0, OP_ADDI, "addi");
    check("addi retired", retired_a, 1);

    run_instr(0, OP_LW, "lw");
    run_instr(0, OP_SW, "sw");
    run_instr(0, OP_CALL, "call");
    run_instr(0, OP_RET, "ret");
    check("mem/stack retired", retired_a, 5);

    // SW with a 3-cycle stall in stage 2
    opcode_a = OP_SW;
    #2; check("stl stage0", stage_a, 0); tick();
    #2; check("stl stage1", stage_a, 1); check("stl op_q", op_q_a, OP_SW); tick();
    stall_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      check("stl held stage", stage_a, 2);
      check("stl held strobes", strb_a, 0);
      tick();
    end
    stall_a = 1'b0;
    #2; check("stl rel stage", stage_a, 2); check("stl rel strobes", strb_a, 7'b0010000); tick();
    #2; check("stl s3 strobes", strb_a, 7'b1000000); tick();
    #2; check("stl s4 strobes", strb_a, 7'b0000001); tick();
    #2; check("stl next stage", stage_a, 0); check("stl retired", retired_a, 6);

    // HALT with a 1-cycle stall on the final stage
    opcode_a = OP_HALT;
    for (int s = 0; s < 4; s++) begin
      #2;
      check("halt stage", stage_a, s);
      check("halt strobes", strb_a, exp_strb(OP_HALT, s, 5, 3, 2, 2));
      tick();
    end
    stall_a = 1'b1;
    #2;
    check("halt stl strobes", strb_a, 0);
    check("halt stl stage", stage_a, 4);
    tick();
    check("halt stl halted", halted_a, 0);
    stall_a = 1'b0;
    #2; check("halt done strobes", strb_a, 7'b0000001); tick();
    #2;
    check("halt halted", halted_a, 1);
    check("halt stage0", stage_a, 0);
    check("halt retired", retired_a, 7);
    opcode_a = OP_CALL;
    for (int i = 0; i < 10; i++) begin
      stall_a = i[0];
      tick();
      #2;
      check("hlt idle halted", halted_a, 1);
      check("hlt idle stage", stage_a, 0);
      check("hlt idle strobes", strb_a, 0);
    end
    stall_a = 1'b0;
    tick();
    resume_a = 1'b1;
    #2; check("resume halted before", halted_a, 1);
    tick();
    resume_a = 1'b0;
    #2;
    check("resume halted after", halted_a, 0);
    check("resume stage", stage_a, 0);
    check("resume op_q held", op_q_a, OP_HALT);
    run_instr(0, OP_ADDI, "post-resume addi");
    check("resume retired", retired_a, 8);

    // Reset pulled in stage 3 of a CALL
    opcode_a = OP_CALL;
    for (int s = 0; s < 3; s++) begin
      #2;
      check("mrst stage", stage_a, s);
      check("mrst strobes", strb_a, exp_strb(OP_CALL, s, 5, 3, 2, 2));
      tick();
    end
    #2;
    check("mrst pc at s3", strb_a, 7'b1000000);
    reset = 1'b0;
    #1;
    check("mrst stage", stage_a, 0);
    check("mrst op_q", op_q_a, 0);
    check("mrst retired", retired_a, 0);
    check("mrst strobes", strb_a, 0);
    check("mrst halted", halted_a, 0);
    tick();
    tick();
    reset = 1'b1;
    run_instr(0, OP_ADDI, "mrst addi");
    check("mrst after retired", retired_a, 1);

    // 8-stage instance, 2-bit retired counter
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #2; check("p8 retired0", retired_b, 0);
    tick();
    reset = 1'b0;
    #1;
    reset = 1'b1;
    run_instr(1, OP_LW, "p8 lw");
    check("p8 retired1", retired_b, 1);
    run_instr(1, OP_SW, "p8 sw");
    check("p8 retired2", retired_b, 2);
    run_instr(1, OP_CALL, "p8 call");
    check("p8 retired3", retired_b, 3);
    run_instr(1, OP_ADDI, "p8 addi");
    check("p8 retired wrap", retired_b, 0);
    run_instr(1, OP_RET, "p8 ret");
    check("p8 retired5", retired_b, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
